mem_interface_unit: RTL and testbench
=====================================

// Module: mem_interface_unit
// PURPOSE
//  Responder side of the instruction-unit load/store handshake. Accepts one
//  load (1 byte) or store (16-bit result, two byte beats) from the instruction
//  unit and runs req/resp beats on the 8-bit main-memory bus. Returns read data
//  with a 1-cycle mem_done pulse. A per-beat timeout aborts a stalled access.
// PARAMETERS
//  ADDR_W   14   memory address width (byte address)
//  DATA_W   8    memory data width
//  TIMEOUT  255  max cycles a beat waits for mem_resp before abort (1..255)
// PORTS
//  clk        in   1       clock, all logic on posedge
//  reset_n    in   1       synchronous, active-low reset
//  load       in   1       IU load request; held until mem_done seen
//  store      in   1       IU store request; held until mem_done seen
//  Addr       in   ADDR_W  IU byte address; stable while load/store high
//  result     in   16      IU store data; stable while store high
//  data       out  DATA_W  read byte to IU; valid when mem_done=1
//  mem_done   out  1       1-cycle completion pulse to IU
//  mem_err    out  1       valid with mem_done: timeout or illegal request
//  mem_req    out  1       memory beat request; held until mem_resp
//  mem_we     out  1       1=write beat, 0=read beat; stable while mem_req
//  mem_addr   out  ADDR_W  beat address; stable while mem_req
//  mem_wdata  out  DATA_W  write byte; stable while mem_req
//  mem_rdata  in   DATA_W  read byte; sampled when mem_resp=1
//  mem_resp   in   1       memory beat acknowledge
// BEHAVIOUR
//  Reset (next edge with reset_n=0): state IDLE; data, mem_addr, mem_wdata =0;
//   mem_done, mem_err, mem_req, mem_we =0; timer =0. All outputs registered.
//  States: IDLE, RD, WR_LO, GAP, WR_HI, DONE.
//  IDLE: load&!store -> RD (mem_we=0, mem_addr=Addr). store&!load -> WR_LO
//   (mem_we=1, mem_addr=Addr, mem_wdata=result[7:0], result[15:8] latched).
//   load&store -> DONE with mem_err=1, no memory beat. Neither -> stay.
//  mem_req=1 throughout RD/WR_LO/WR_HI. Beat completes on an edge with mem_resp=1;
//   mem_req is 0 in the cycle after that edge (always >=1 idle cycle between beats).
//  RD + resp: data<=mem_rdata -> DONE. WR_LO + resp -> GAP (mem_req=0).
//  GAP -> WR_HI: mem_addr<=mem_addr+1 (ADDR_W wrap, 0x3FFF->0x0000),
//   mem_wdata<=latched result[15:8]. WR_HI + resp -> DONE.
//  DONE: mem_done=1 for exactly one cycle -> IDLE. IU drops load/store on the
//   same edge, so the IDLE entered next never re-triggers.
//  Latency (load, resp on 1st req cycle): load sampled edge0, mem_req high
//   cycle1, resp sampled edge1, mem_done high cycle2.
//  Store w/ immediate resps: mem_done 4 cycles after request sample.
//  Timer: cleared on entry to each RD/WR_LO/WR_HI. Increments per cycle with no
//   resp. Reaching TIMEOUT -> DONE, mem_err=1, mem_req drops. Aborted load
//   returns data=0x00. Aborted WR_LO skips WR_HI. resp on the TIMEOUT cycle
//   counts as success.
//  mem_err clears at the DONE->IDLE edge. mem_resp outside RD/WR_* is ignored.
//  Reset mid-beat: mem_req drops at that edge; the memory must tolerate the
//   abandoned beat. A load/store still high after reset starts a new access.
//  load/store changing mid-access: ignored until IDLE.
// STRUCTURE
//  tinyalu_pkg gains miu_state_t enum and MEM_ADDR_W=14, MEM_DATA_W=8.
//  Sub-module miu_beat_timer (clear, enable, timeout flag, 8-bit count).
//  The FSM and datapath stay in this module.
// TESTING
//  1 load Addr=0x010, memory resp after 2 waits w/ rdata=0xA5 -> mem_req
//    3 cycles, data=0xA5, mem_done 1 cycle, mem_err=0.
//  2 store Addr=0x011 result=0xBEEF, 0-wait resps -> beats (0x011,0xEF) then
//    (0x012,0xBE), 1 cycle mem_req=0 between, single mem_done.
//  3 store Addr=0x3FFF result=0x1234 -> beats (0x3FFF,0x34),(0x0000,0x12).
//  4 load, no resp, TIMEOUT=4 -> mem_req drops after 4 cycles, mem_done+mem_err,
//    data=0x00; store with WR_LO stalled -> no WR_HI beat.
//  5 load=store=1 -> no mem_req, mem_done+mem_err next cycle.
//  6 reset_n=0 during WR_HI wait -> all outputs 0 next edge, IDLE. Back-to-back
//    loads after reset each produce exactly one mem_done.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared types and constants for the memory interface unit.
//   MEM_ADDR_W  byte address width of the main-memory bus
//   MEM_DATA_W  data width of the main-memory bus
//   miu_state_t FSM encodings of the memory interface unit
package tinyalu_pkg;

    localparam int MEM_ADDR_W = 14;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [2:0] {
        MIU_IDLE  = 3'd0,
        MIU_RD    = 3'd1,
        MIU_WR_LO = 3'd2,
        MIU_GAP   = 3'd3,
        MIU_WR_HI = 3'd4,
        MIU_DONE  = 3'd5
    } miu_state_t;

    // True for the states that hold an outstanding memory beat
    function automatic logic is_beat_state(input logic [2:0] st);
        return (st == 3'(MIU_RD)) || (st == 3'(MIU_WR_LO)) || (st == 3'(MIU_WR_HI));
    endfunction

endpackage

// File: rtl/mem_interface_unit_if.sv
// mem_interface_unit_if: groups the instruction-unit handshake and the
// main-memory beat bus of the memory interface unit.
//   IU side    : load, store, Addr, result -> unit; data, mem_done, mem_err <- unit
//   memory side: mem_req, mem_we, mem_addr, mem_wdata <- unit; mem_rdata, mem_resp -> unit
// Modports:
//   master : the memory interface unit itself (drives the memory bus and
//            the completion signals)
//   slave  : its environment (instruction unit plus main memory)
interface mem_interface_unit_if
    import tinyalu_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic              load;
    logic              store;
    logic [ADDR_W-1:0] Addr;
    logic [15:0]       result;
    logic [DATA_W-1:0] data;
    logic              mem_done;
    logic              mem_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport master (
        input  load, store, Addr, result, mem_rdata, mem_resp,
        output data, mem_done, mem_err, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output load, store, Addr, result, mem_rdata, mem_resp,
        input  data, mem_done, mem_err, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_interface_unit_beat_timer.sv
// miu_beat_timer: per-beat wait counter of the memory interface unit.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : forces the count to zero (unit not waiting on a beat)
//   enable       : a beat cycle passed without a response
//   timeout      : this non-responding cycle is the last one the beat may wait
// The 8-bit count is internal; only the expiry flag leaves the block.
module miu_beat_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [7:0] count_r;

    // Wait-cycle counter, restarted whenever no beat is outstanding
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Expiry fires on the TIMEOUT-th unanswered cycle; a response in that
    // same cycle deasserts enable, so it still completes normally.
    assign timeout = enable && (count_r == LAST_WAIT);

endmodule

// File: rtl/mem_interface_unit.sv
// mem_interface_unit: responder for instruction-unit loads/stores that runs
// byte beats on the 8-bit main-memory bus.
//   clk      : clock, all logic on posedge
//   reset_n  : synchronous, active-low reset
//   bus      : mem_interface_unit_if.master
//     load/store/Addr/result      request from the instruction unit
//     data/mem_done/mem_err       completion back to the instruction unit
//     mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_resp  memory beat bus
// A load is one read beat; a store is a low-byte write beat at Addr, one idle
// cycle, then a high-byte write beat at Addr+1. Every beat is guarded by a
// timeout that ends the access with mem_err. All outputs are registered.
module mem_interface_unit
    import tinyalu_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_interface_unit_if.master bus
);

    localparam logic [2:0] ST_IDLE  = MIU_IDLE;
    localparam logic [2:0] ST_RD    = MIU_RD;
    localparam logic [2:0] ST_WR_LO = MIU_WR_LO;
    localparam logic [2:0] ST_GAP   = MIU_GAP;
    localparam logic [2:0] ST_WR_HI = MIU_WR_HI;
    localparam logic [2:0] ST_DONE  = MIU_DONE;

    logic [2:0]        state_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [DATA_W-1:0] hi_byte_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_done_r;
    logic              mem_err_r;
    logic              mem_req_r;
    logic              mem_we_r;

    logic in_beat_s;
    logic timer_en_s;
    logic timeout_s;

    assign in_beat_s  = is_beat_state(state_r);
    assign timer_en_s = in_beat_s && !bus.mem_resp;

    miu_beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_beat_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_beat_s),
        .enable  (timer_en_s),
        .timeout (timeout_s)
    );

    // Access sequencer and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            data_r      <= {DATA_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            hi_byte_r   <= {DATA_W{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_done_r  <= 1'b0;
            mem_err_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.load && !bus.store) begin
                        state_r    <= ST_RD;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= bus.Addr;
                        data_r     <= {DATA_W{1'b0}};
                    end else if (bus.store && !bus.load) begin
                        state_r     <= ST_WR_LO;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= bus.Addr;
                        mem_wdata_r <= bus.result[7:0];
                        hi_byte_r   <= bus.result[15:8];
                    end else if (bus.load && bus.store) begin
                        // Contradictory request: fail it without touching memory
                        state_r    <= ST_DONE;
                        mem_done_r <= 1'b1;
                        mem_err_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_RD: begin
                    if (bus.mem_resp) begin
                        state_r    <= ST_DONE;
                        data_r     <= bus.mem_rdata;
                        mem_req_r  <= 1'b0;
                        mem_done_r <= 1'b1;
                    end else if (timeout_s) begin
                        state_r    <= ST_DONE;
                        data_r     <= {DATA_W{1'b0}};
                        mem_req_r  <= 1'b0;
                        mem_done_r <= 1'b1;
                        mem_err_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RD;
                    end
                end

                ST_WR_LO: begin
                    if (bus.mem_resp) begin
                        state_r   <= ST_GAP;
                        mem_req_r <= 1'b0;
                    end else if (timeout_s) begin
                        // The high byte is never written after a failed low beat
                        state_r    <= ST_DONE;
                        mem_req_r  <= 1'b0;
                        mem_we_r   <= 1'b0;
                        mem_done_r <= 1'b1;
                        mem_err_r  <= 1'b1;
                    end else begin
                        state_r <= ST_WR_LO;
                    end
                end

                ST_GAP: begin
                    // Address increment wraps within the ADDR_W byte space
                    state_r     <= ST_WR_HI;
                    mem_req_r   <= 1'b1;
                    mem_addr_r  <= mem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    mem_wdata_r <= hi_byte_r;
                end

                ST_WR_HI: begin
                    if (bus.mem_resp) begin
                        state_r    <= ST_DONE;
                        mem_req_r  <= 1'b0;
                        mem_we_r   <= 1'b0;
                        mem_done_r <= 1'b1;
                    end else if (timeout_s) begin
                        state_r    <= ST_DONE;
                        mem_req_r  <= 1'b0;
                        mem_we_r   <= 1'b0;
                        mem_done_r <= 1'b1;
                        mem_err_r  <= 1'b1;
                    end else begin
                        state_r <= ST_WR_HI;
                    end
                end

                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    mem_done_r <= 1'b0;
                    mem_err_r  <= 1'b0;
                end

                default: begin
                    state_r    <= ST_IDLE;
                    mem_req_r  <= 1'b0;
                    mem_we_r   <= 1'b0;
                    mem_done_r <= 1'b0;
                    mem_err_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_r;
    assign bus.mem_done  = mem_done_r;
    assign bus.mem_err   = mem_err_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Testbench for mem_interface_unit: acts as instruction unit and main memory.
// Expected beats and completions are queued when a request is issued and
// compared when the unit produces them.
module tb_mem_interface_unit;
    import tinyalu_pkg::*;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int TO = 4;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } beat_t;

    typedef struct {
        logic          err;
        logic          chk_data;
        logic [DW-1:0] data;
        int            latency;
    } done_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    beat_t exp_beats[$];
    done_t exp_done[$];

    always #5 clk = ~clk;

    mem_interface_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_interface_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic idle_inputs();
        bus.load      = 1'b0;
        bus.store     = 1'b0;
        bus.Addr      = '0;
        bus.result    = 16'h0000;
        bus.mem_rdata = 8'h00;
        bus.mem_resp  = 1'b0;
    endtask

    task automatic push_beat(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        beat_t b;
        b.we = we; b.addr = a; b.wdata = d;
        exp_beats.push_back(b);
    endtask

    task automatic push_done(input logic err, input logic chk, input logic [DW-1:0] d, input int lat);
        done_t e;
        e.err = err; e.chk_data = chk; e.data = d; e.latency = lat;
        exp_done.push_back(e);
    endtask

    // Issue one IU request and play memory: answer beat k after 'waits' wait
    // cycles, never answer the beat whose index is stall_beat.
    task automatic run_access(input logic ld, input logic st, input logic [AW-1:0] a,
                              input logic [15:0] res, input int waits,
                              input logic [DW-1:0] rdata, input int stall_beat,
                              input int exp_req_cycles, input string name);
        int    cyc = 0, beat = -1, beat_cyc = 0, req_cycles = 0, dones = 0, done_at = -1;
        logic  prev_req = 1'b0, prev_resp = 1'b0;
        beat_t eb;
        done_t ed;
        @(negedge clk);
        bus.load = ld; bus.store = st; bus.Addr = a; bus.result = res; bus.mem_resp = 1'b0;
        while (cyc < 40 && !(done_at >= 0 && cyc >= done_at + 2)) begin
            @(negedge clk);
            cyc++;
            bus.mem_resp = 1'b0;
            if (prev_resp) begin
                n_tests++;
                if (bus.mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s req_after_resp: mem_req=%b required 0", name, bus.mem_req);
                end
            end
            if (bus.mem_req === 1'b1) begin
                req_cycles++;
                if (!prev_req) begin
                    beat++;
                    beat_cyc = 0;
                    n_tests++;
                    if (exp_beats.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s unexpected_beat: we=%b addr=%h wdata=%h required none",
                                 name, bus.mem_we, bus.mem_addr, bus.mem_wdata);
                    end else begin
                        eb = exp_beats.pop_front();
                        if (bus.mem_we !== eb.we || bus.mem_addr !== eb.addr ||
                            (eb.we && bus.mem_wdata !== eb.wdata)) begin
                            n_fail++;
                            $display("FAIL %s beat%0d: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                                     name, beat, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                     eb.we, eb.addr, eb.wdata);
                        end
                    end
                end
                beat_cyc++;
                if (beat != stall_beat && beat_cyc > waits) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = rdata;
                end
            end
            if (bus.mem_done === 1'b1) begin
                dones++;
                n_tests++;
                if (dones > 1) begin
                    n_fail++;
                    $display("FAIL %s extra_done: mem_done count=%0d required 1", name, dones);
                end else begin
                    done_at   = cyc;
                    bus.load  = 1'b0;
                    bus.store = 1'b0;
                    ed = exp_done.pop_front();
                    if (bus.mem_err !== ed.err || bus.mem_req !== 1'b0 ||
                        (ed.chk_data && bus.data !== ed.data) ||
                        (ed.latency >= 0 && cyc != ed.latency)) begin
                        n_fail++;
                        $display("FAIL %s done: err=%b data=%h req=%b latency=%0d required err=%b data=%h req=0 latency=%0d",
                                 name, bus.mem_err, bus.data, bus.mem_req, cyc, ed.err, ed.data, ed.latency);
                    end
                end
            end
            prev_req  = bus.mem_req;
            prev_resp = bus.mem_resp;
        end
        n_tests++;
        if (done_at < 0 || exp_beats.size() != 0) begin
            n_fail++;
            $display("FAIL %s completion: done_seen=%0d beats_left=%0d required done_seen=1 beats_left=0",
                     name, dones, exp_beats.size());
        end
        if (exp_req_cycles >= 0) begin
            n_tests++;
            if (req_cycles != exp_req_cycles) begin
                n_fail++;
                $display("FAIL %s req_cycles: %0d required %0d", name, req_cycles, exp_req_cycles);
            end
        end
        exp_beats.delete();
        exp_done.delete();
        bus.load = 1'b0; bus.store = 1'b0; bus.mem_resp = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.data, bus.mem_addr, bus.mem_wdata, bus.mem_done, bus.mem_err,
             bus.mem_req, bus.mem_we} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: data=%h addr=%h wdata=%h done=%b err=%b req=%b we=%b required all 0",
                     bus.data, bus.mem_addr, bus.mem_wdata, bus.mem_done, bus.mem_err,
                     bus.mem_req, bus.mem_we);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_load();
        push_beat(1'b0, 14'h0010, 8'h00);
        push_done(1'b0, 1'b1, 8'hA5, 4);
        run_access(1'b1, 1'b0, 14'h0010, 16'h0000, 2, 8'hA5, -1, 3, "load_2wait");
        push_beat(1'b0, 14'h2ABC, 8'h00);
        push_done(1'b0, 1'b1, 8'h3C, 2);
        run_access(1'b1, 1'b0, 14'h2ABC, 16'h0000, 0, 8'h3C, -1, 1, "load_0wait");
    endtask

    task automatic test_store();
        logic [15:0] r;
        logic [AW-1:0] a;
        push_beat(1'b1, 14'h0011, 8'hEF);
        push_beat(1'b1, 14'h0012, 8'hBE);
        push_done(1'b0, 1'b0, 8'h00, 4);
        run_access(1'b0, 1'b1, 14'h0011, 16'hBEEF, 0, 8'h00, -1, 2, "store_0wait");
        push_beat(1'b1, 14'h3FFF, 8'h34);
        push_beat(1'b1, 14'h0000, 8'h12);
        push_done(1'b0, 1'b0, 8'h00, 4);
        run_access(1'b0, 1'b1, 14'h3FFF, 16'h1234, 0, 8'h00, -1, 2, "store_wrap");
        for (int i = 0; i < 3; i++) begin
            r = 16'($urandom);
            a = 14'($urandom);
            push_beat(1'b1, a, r[7:0]);
            push_beat(1'b1, a + 14'd1, r[15:8]);
            push_done(1'b0, 1'b0, 8'h00, 4 + 2 * i);
            run_access(1'b0, 1'b1, a, r, i, 8'h00, -1, 2 * (i + 1), "store_rand");
        end
    endtask

    task automatic test_timeout();
        push_beat(1'b0, 14'h0100, 8'h00);
        push_done(1'b1, 1'b1, 8'h00, TO + 1);
        run_access(1'b1, 1'b0, 14'h0100, 16'h0000, 0, 8'hFF, 0, TO, "load_timeout");
        push_beat(1'b0, 14'h0101, 8'h00);
        push_done(1'b0, 1'b1, 8'h77, TO + 1);
        run_access(1'b1, 1'b0, 14'h0101, 16'h0000, TO - 1, 8'h77, -1, TO, "load_resp_on_last");
        push_beat(1'b1, 14'h0200, 8'h22);
        push_done(1'b1, 1'b0, 8'h00, TO + 1);
        run_access(1'b0, 1'b1, 14'h0200, 16'h1122, 0, 8'h00, 0, TO, "store_lo_timeout");
        push_beat(1'b1, 14'h0300, 8'h44);
        push_beat(1'b1, 14'h0301, 8'h33);
        push_done(1'b1, 1'b0, 8'h00, TO + 3);
        run_access(1'b0, 1'b1, 14'h0300, 16'h3344, 0, 8'h00, 1, TO + 1, "store_hi_timeout");
    endtask

    task automatic test_illegal();
        push_done(1'b1, 1'b0, 8'h00, 1);
        run_access(1'b1, 1'b1, 14'h0400, 16'hFFFF, 0, 8'h00, -1, 0, "load_and_store");
    endtask

    task automatic test_reset_mid_beat();
        int seen = 0;
        logic prev_req = 1'b0;
        @(negedge clk);
        bus.store = 1'b1; bus.Addr = 14'h0150; bus.result = 16'h5AC3;
        for (int c = 0; c < 12 && seen < 2; c++) begin
            @(negedge clk);
            bus.mem_resp = 1'b0;
            if (bus.mem_req && !prev_req) begin
                seen++;
                if (seen == 1) bus.mem_resp = 1'b1;
            end
            prev_req = bus.mem_req;
        end
        n_tests++;
        if (seen != 2 || bus.mem_addr !== 14'h0151 || bus.mem_wdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_mid_hi_beat: beats=%0d addr=%h wdata=%h required beats=2 addr=0151 wdata=5A",
                     seen, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        reset_n = 1'b0;
        bus.store = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.data, bus.mem_addr, bus.mem_wdata, bus.mem_done, bus.mem_err,
             bus.mem_req, bus.mem_we} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: addr=%h wdata=%h done=%b err=%b req=%b we=%b required all 0",
                     bus.mem_addr, bus.mem_wdata, bus.mem_done, bus.mem_err, bus.mem_req, bus.mem_we);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.mem_req !== 1'b0 || bus.mem_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: req=%b done=%b required 0 0", bus.mem_req, bus.mem_done);
        end
    endtask

    task automatic test_back_to_back();
        push_beat(1'b0, 14'h0020, 8'h00);
        push_done(1'b0, 1'b1, 8'h5C, 2);
        run_access(1'b1, 1'b0, 14'h0020, 16'h0000, 0, 8'h5C, -1, 1, "b2b_load0");
        push_beat(1'b0, 14'h0021, 8'h00);
        push_done(1'b0, 1'b1, 8'hC5, 3);
        run_access(1'b1, 1'b0, 14'h0021, 16'h0000, 1, 8'hC5, -1, 2, "b2b_load1");
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_timeout();
        test_illegal();
        test_reset_mid_beat();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
